// File: rtl/axi4_lite_master_bridge_if.sv
// AXI4-Lite channel bundle shared by the core bridge and the interconnect.
// Only the signals the bridge uses are carried; protection bits are fixed upstream.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Bridge from the RV32IM core's single-outstanding load/store port to an
// AXI4-Lite master. One request is registered, driven out on AW/W or AR, and
// completed with a one-cycle mem_done pulse carrying read data and error status.
package axi4_lite_addr_map_package;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
endpackage

module axi4_lite_master_bridge #(
    parameter int ADDR_WIDTH = axi4_lite_addr_map_package::ADDR_WIDTH,
    parameter int DATA_WIDTH = axi4_lite_addr_map_package::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_busy,
    output logic                    mem_done,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_err,
    axi4_lite_if.master             m_if
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] S_WR_RESP      = 3'd2;
    localparam logic [2:0] S_RD_ADDR      = 3'd3;
    localparam logic [2:0] S_RD_DATA      = 3'd4;

    logic [2:0]              state_q,   state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q,  w_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q,   wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q,  bready_d;
    logic                    rready_q,  rready_d;
    logic                    done_q,    done_d;
    logic                    err_q,     err_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic                    aw_hs;
    logic                    w_hs;

    // Handshakes only count while this bridge is actually presenting VALID.
    assign aw_hs = awvalid_q & m_if.awready;
    assign w_hs  = wvalid_q  & m_if.wready;

    // Next-state and next-output logic; every AXI output is taken from a register.
    always_comb begin
        // NOTE: every target gets a hold/default value first so no path through the case leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    // The transfer direction lives in the state encoding from here on.
                    addr_d    = mem_addr;
                    wdata_d   = mem_wdata;
                    wstrb_d   = mem_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (mem_we) begin
                        state_d   = S_WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            S_WR_ADDR_DATA: begin
                // AW and W complete independently; each VALID drops after its own handshake.
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awvalid_d = 1'b0;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wvalid_d = 1'b0;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end

            S_WR_RESP: begin
                if (m_if.bvalid) begin
                    state_d  = S_IDLE;
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = (m_if.bresp != 2'b00);
                end
            end

            S_RD_ADDR: begin
                if (m_if.arready) begin
                    state_d   = S_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end

            S_RD_DATA: begin
                if (m_if.rvalid) begin
                    state_d  = S_IDLE;
                    rready_d = 1'b0;
                    rdata_d  = m_if.rdata;
                    done_d   = 1'b1;
                    err_d    = (m_if.rresp != 2'b00);
                end
            end

            default: begin
                state_d   = S_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
                bready_d  = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign m_if.awaddr  = addr_q;
    assign m_if.araddr  = addr_q;
    assign m_if.wdata   = wdata_q;
    assign m_if.wstrb   = wstrb_q;
    assign m_if.awvalid = awvalid_q;
    assign m_if.wvalid  = wvalid_q;
    assign m_if.arvalid = arvalid_q;
    assign m_if.bready  = bready_q;
    assign m_if.rready  = rready_q;

    assign mem_busy  = (state_q != S_IDLE);
    assign mem_done  = done_q;
    assign mem_err   = err_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed bench for axi4_lite_master_bridge. The bench plays the AXI slave,
// drives inputs and samples outputs on the falling clock edge.
module tb_axi4_lite_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_busy;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int vectors    = 0;
    int miscompares = 0;

    axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi4_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .m_if      (axi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
    endtask

    initial begin
        logic seen;
        rst         = 1'b1;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;

        // Reset state
        tick(); tick();
        check("rst_busy",    mem_busy,    0);
        check("rst_done",    mem_done,    0);
        check("rst_err",     mem_err,     0);
        check("rst_rdata",   mem_rdata,   0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid",  axi.wvalid,  0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_bready",  axi.bready,  0);
        check("rst_rready",  axi.rready,  0);
        check("rst_awaddr",  axi.awaddr,  0);
        rst = 1'b0;
        tick();

        // 1. Load, zero wait states
        request(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        check("t1_idle_busy", mem_busy, 0);
        tick();
        check("t1_busy",    mem_busy,    1);
        check("t1_arvalid", axi.arvalid, 1);
        check("t1_araddr",  axi.araddr,  32'h0000_1000);
        check("t1_awvalid", axi.awvalid, 0);
        check("t1_rready0", axi.rready,  0);
        mem_req = 1'b0;
        axi.arready = 1'b1;
        tick();
        check("t1_arvalid_drop", axi.arvalid, 0);
        check("t1_rready",       axi.rready,  1);
        check("t1_done_early",   mem_done,    0);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'hDEAD_BEEF;
        axi.rresp   = 2'b00;
        tick();
        check("t1_done",  mem_done,  1);
        check("t1_rdata", mem_rdata, 32'hDEAD_BEEF);
        check("t1_err",   mem_err,   0);
        check("t1_busy0", mem_busy,  0);
        axi.rvalid = 1'b0;
        tick();
        check("t1_done_pulse", mem_done, 0);

        // 2. Store, W before AW
        request(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011);
        tick();
        check("t2_awvalid", axi.awvalid, 1);
        check("t2_wvalid",  axi.wvalid,  1);
        check("t2_awaddr",  axi.awaddr,  32'h0000_2004);
        check("t2_wdata",   axi.wdata,   32'h1234_5678);
        check("t2_wstrb",   axi.wstrb,   4'b0011);
        check("t2_arvalid", axi.arvalid, 0);
        mem_req  = 1'b0;
        mem_addr = 32'hFFFF_FFFC;
        tick();
        axi.wready = 1'b1;
        check("t2_wvalid_pre", axi.wvalid, 1);
        tick();
        axi.wready = 1'b0;
        check("t2_wvalid_drop", axi.wvalid,  0);
        check("t2_awvalid_hold", axi.awvalid, 1);
        check("t2_awaddr_hold", axi.awaddr,  32'h0000_2004);
        check("t2_bready0",     axi.bready,  0);
        mem_req = 1'b1;
        tick();
        mem_req = 1'b0;
        check("t2_wvalid_stays0", axi.wvalid,  0);
        check("t2_awvalid_hold2", axi.awvalid, 1);
        check("t2_awaddr_hold2",  axi.awaddr,  32'h0000_2004);
        tick();
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        check("t2_awvalid_drop", axi.awvalid, 0);
        check("t2_bready",       axi.bready,  1);
        check("t2_busy",         mem_busy,    1);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b00;
        tick();
        axi.bvalid = 1'b0;
        check("t2_done",   mem_done, 1);
        check("t2_err",    mem_err,  0);
        check("t2_busy0",  mem_busy, 0);
        check("t2_bready_drop", axi.bready, 0);
        tick();
        check("t2_done_single", mem_done, 0);

        // 3 + 4. Simultaneous AW/W, store returns SLVERR
        request(1'b1, 32'h0000_3000, 32'hA5A5_0F0F, 4'hF);
        tick();
        mem_req = 1'b0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        tick();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        check("t3_awvalid0", axi.awvalid, 0);
        check("t3_wvalid0",  axi.wvalid,  0);
        check("t3_bready",   axi.bready,  1);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b10;
        tick();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        check("t4_wr_done", mem_done, 1);
        check("t4_wr_err",  mem_err,  1);
        check("t4_wr_busy0", mem_busy, 0);
        tick();
        check("t4_wr_err_clear", mem_err, 0);

        // 4. Load returns DECERR
        request(1'b0, 32'h0000_8000, 32'h0, 4'h0);
        tick();
        mem_req = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h0000_0000;
        axi.rresp   = 2'b11;
        tick();
        axi.rvalid = 1'b0;
        axi.rresp  = 2'b00;
        check("t4_rd_done",  mem_done, 1);
        check("t4_rd_err",   mem_err,  1);
        check("t4_rd_busy0", mem_busy, 0);

        // 5. Requests ignored while RVALID stalls, then back-to-back acceptance
        request(1'b0, 32'h0000_4000, 32'h0, 4'h0);
        tick();
        mem_req = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_req  = ~mem_req;
            mem_we   = i[0];
            mem_addr = 32'h0000_9000 + 32'(i * 4);
            tick();
            check("t5_araddr",  axi.araddr,  32'h0000_4000);
            check("t5_arvalid", axi.arvalid, 0);
            check("t5_awvalid", axi.awvalid, 0);
            check("t5_busy",    mem_busy,    1);
            check("t5_done",    mem_done,    0);
        end
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h1357_9BDF;
        tick();
        axi.rvalid = 1'b0;
        check("t5_done_a",  mem_done,  1);
        check("t5_rdata_a", mem_rdata, 32'h1357_9BDF);
        request(1'b0, 32'h0000_5000, 32'h0, 4'h0);
        tick();
        mem_req = 1'b0;
        check("t5_b2b_arvalid", axi.arvalid, 1);
        check("t5_b2b_araddr",  axi.araddr,  32'h0000_5000);
        check("t5_b2b_busy",    mem_busy,    1);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'hCAFE_F00D;
        tick();
        axi.rvalid = 1'b0;
        check("t5_done_b",  mem_done,  1);
        check("t5_rdata_b", mem_rdata, 32'hCAFE_F00D);

        // 6. Reset while waiting in WR_RESP
        request(1'b1, 32'h0000_6000, 32'h55AA_55AA, 4'hF);
        tick();
        mem_req = 1'b0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        tick();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        check("t6_bready", axi.bready, 1);
        rst = 1'b1;
        tick();
        check("t6_busy",    mem_busy,    0);
        check("t6_awvalid", axi.awvalid, 0);
        check("t6_wvalid",  axi.wvalid,  0);
        check("t6_arvalid", axi.arvalid, 0);
        check("t6_bready0", axi.bready,  0);
        check("t6_done",    mem_done,    0);
        check("t6_awaddr",  axi.awaddr,  0);
        rst = 1'b0;
        tick();
        check("t6_no_done", mem_done, 0);
        check("t6_idle",    mem_busy, 0);
        request(1'b0, 32'h0000_7000, 32'h0, 4'h0);
        tick();
        mem_req = 1'b0;
        check("t6_next_araddr", axi.araddr, 32'h0000_7000);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h0BAD_F00D;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (mem_done) begin
                seen = 1'b1;
                check("t6_next_rdata", mem_rdata, 32'h0BAD_F00D);
                check("t6_next_err",   mem_err,   0);
            end
            axi.rvalid = 1'b0;
        end
        check("t6_next_done_seen", seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
